// File: rtl/sync_fifo_mm.sv
// sync_fifo_mm: single-clock FIFO with standard or first-word-fall-through read,
// level flags, same-cycle error strobes and sticky error flags.
module sync_fifo_mm #(
    parameter int DATA_WIDTH             = 16,
    parameter int DEPTH                  = 1024,
    parameter int ALMOST_FULL_THRESHOLD  = 16,
    parameter int ALMOST_EMPTY_THRESHOLD = 16,
    parameter int FWFT                   = 0,
    parameter int ADDR_WIDTH             = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  overflow_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic                  underflow_o,
    output logic [ADDR_WIDTH:0]   fill_count_o,
    input  logic                  err_clr_i,
    output logic                  ovf_sticky_o,
    output logic                  udf_sticky_o
);
    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] L_AF    = (ADDR_WIDTH+1)'(DEPTH - ALMOST_FULL_THRESHOLD);
    localparam logic [ADDR_WIDTH:0] L_AE    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESHOLD);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid, r_ovf, r_udf;
    logic [ADDR_WIDTH:0]   w_mem_cnt, w_fill;
    logic                  w_wr, w_mem_rd, w_valid_nxt;

    assign w_mem_cnt = r_wr_ptr - r_rd_ptr;
    // In FWFT mode the word parked in the output register still counts as held
    assign w_fill = (FWFT != 0) ? w_mem_cnt + {{ADDR_WIDTH{1'b0}}, r_rd_valid} : w_mem_cnt;

    assign fill_count_o   = w_fill;
    assign full_o         = (w_fill == L_DEPTH);
    assign almost_full_o  = (w_fill >= L_AF);
    assign almost_empty_o = (w_fill <= L_AE);
    assign empty_o        = (FWFT != 0) ? ~r_rd_valid : (w_fill == '0);
    assign overflow_o     = wr_en_i && full_o;
    assign underflow_o    = rd_en_i && empty_o;
    assign rd_data_o      = r_rd_data;
    assign rd_valid_o     = r_rd_valid;
    assign ovf_sticky_o   = r_ovf;
    assign udf_sticky_o   = r_udf;

    assign w_wr = wr_en_i && !full_o;
    // FWFT refills the output register whenever it is free or being popped
    assign w_mem_rd    = (FWFT != 0) ? (!r_rd_valid || rd_en_i) && (w_mem_cnt != '0)
                                     : rd_en_i && !empty_o;
    assign w_valid_nxt = (FWFT != 0) ? w_mem_rd || (r_rd_valid && !rd_en_i) : w_mem_rd;

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_wr};
            r_rd_ptr   <= r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_mem_rd};
            if (w_mem_rd) r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            r_rd_valid <= w_valid_nxt;
            r_ovf      <= overflow_o || (r_ovf && !err_clr_i);
            r_udf      <= underflow_o || (r_udf && !err_clr_i);
        end
    end
endmodule

// File: tb/tb_sync_fifo_mm.sv
// tb_sync_fifo_mm: drives a standard-read and an FWFT instance with identical stimulus
// and checks both against per-mode queue models every cycle.
module tb_sync_fifo_mm;
    logic        clk = 1'b0, rst_n = 1'b0, we = 1'b0, re = 1'b0, clr = 1'b0;
    logic [15:0] wd = '0;
    logic        full [2], afull [2], ovf [2], rvalid [2], empty [2], aempty [2], udf [2], ovs [2], uds [2];
    logic [15:0] rdata [2];
    logic [3:0]  fill [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sync_fifo_mm #(
            .DATA_WIDTH(16), .DEPTH(8), .ALMOST_FULL_THRESHOLD(2),
            .ALMOST_EMPTY_THRESHOLD(2), .FWFT(g)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .wr_en_i(we), .wr_data_i(wd),
            .full_o(full[g]), .almost_full_o(afull[g]), .overflow_o(ovf[g]),
            .rd_en_i(re), .rd_data_o(rdata[g]), .rd_valid_o(rvalid[g]),
            .empty_o(empty[g]), .almost_empty_o(aempty[g]), .underflow_o(udf[g]),
            .fill_count_o(fill[g]), .err_clr_i(clr),
            .ovf_sticky_o(ovs[g]), .udf_sticky_o(uds[g])
        );
    end

    int checks = 0, errors = 0;

    // Model: q0 is the standard-mode content; q1/t1 hold FWFT content and the edge each word was written
    logic [15:0] q0 [$], q1 [$];
    int          t1 [$];
    int          n_edge = 0;
    logic [15:0] m0_data = '0;
    bit          m0_valid = 1'b0;
    bit          os [2], us [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // A word written at edge t becomes visible in FWFT mode after edge t+1
    function automatic bit v1();
        return q1.size() > 0 && t1[0] <= n_edge - 1;
    endfunction

    task automatic check_all();
        int f0 = q0.size();
        int f1 = q1.size();
        bit e1 = !v1();
        chk("fill0",   32'(fill[0]),   32'(f0));
        chk("full0",   32'(full[0]),   32'(f0 == 8));
        chk("afull0",  32'(afull[0]),  32'(f0 >= 6));
        chk("aempty0", 32'(aempty[0]), 32'(f0 <= 2));
        chk("empty0",  32'(empty[0]),  32'(f0 == 0));
        chk("ovf0",    32'(ovf[0]),    32'(we && f0 == 8));
        chk("udf0",    32'(udf[0]),    32'(re && f0 == 0));
        chk("rvalid0", 32'(rvalid[0]), 32'(m0_valid));
        chk("rdata0",  32'(rdata[0]),  32'(m0_data));
        chk("ovs0",    32'(ovs[0]),    32'(os[0]));
        chk("uds0",    32'(uds[0]),    32'(us[0]));
        chk("fill1",   32'(fill[1]),   32'(f1));
        chk("full1",   32'(full[1]),   32'(f1 == 8));
        chk("afull1",  32'(afull[1]),  32'(f1 >= 6));
        chk("aempty1", 32'(aempty[1]), 32'(f1 <= 2));
        chk("empty1",  32'(empty[1]),  32'(e1));
        chk("ovf1",    32'(ovf[1]),    32'(we && f1 == 8));
        chk("udf1",    32'(udf[1]),    32'(re && e1));
        chk("rvalid1", 32'(rvalid[1]), 32'(!e1));
        if (!e1) chk("rdata1", 32'(rdata[1]), 32'(q1[0]));
        chk("ovs1",    32'(ovs[1]),    32'(os[1]));
        chk("uds1",    32'(uds[1]),    32'(us[1]));
    endtask

    task automatic step(input bit w, input logic [15:0] d, input bit r, input bit c);
        bit wa0, ra0, wa1, ra1;
        we = w; wd = d; re = r; clr = c;
        #2;
        check_all();
        wa0 = w && q0.size() < 8;
        ra0 = r && q0.size() > 0;
        wa1 = w && q1.size() < 8;
        ra1 = r && v1();
        os[0] = (w && q0.size() == 8) || (os[0] && !c);
        us[0] = (r && q0.size() == 0) || (us[0] && !c);
        os[1] = (w && q1.size() == 8) || (os[1] && !c);
        us[1] = (r && !v1()) || (us[1] && !c);
        @(posedge clk);
        n_edge++;
        m0_valid = ra0;
        if (ra0) begin m0_data = q0[0]; q0.delete(0); end
        if (wa0) q0.push_back(d);
        if (ra1) begin q1.delete(0); t1.delete(0); end
        if (wa1) begin q1.push_back(d); t1.push_back(n_edge); end
        #1;
    endtask

    task automatic do_reset();
        we = 1'b0; re = 1'b0; clr = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_fill",   32'(fill[m]),   32'd0);
            chk("rst_full",   32'(full[m]),   32'd0);
            chk("rst_afull",  32'(afull[m]),  32'd0);
            chk("rst_empty",  32'(empty[m]),  32'd1);
            chk("rst_aempty", 32'(aempty[m]), 32'd1);
            chk("rst_rvalid", 32'(rvalid[m]), 32'd0);
            chk("rst_rdata",  32'(rdata[m]),  32'd0);
            chk("rst_ovs",    32'(ovs[m]),    32'd0);
            chk("rst_uds",    32'(uds[m]),    32'd0);
        end
        q0.delete(); q1.delete(); t1.delete();
        m0_data = '0; m0_valid = 1'b0;
        os[0] = 1'b0; os[1] = 1'b0; us[0] = 1'b0; us[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("fill_full",  32'(full[0]),  32'd1);
        chk("fill_count", 32'(fill[0]),  32'd8);
        chk("fill_afull", 32'(afull[1]), 32'd1);
        step(1'b1, 16'h0009, 1'b0, 1'b0);
        chk("fill_ovs", 32'(ovs[0]), 32'd1);

        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("drain_empty", 32'(empty[0]), 32'd1);
        chk("drain_uds",   32'(uds[0]),   32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_ovs", 32'(ovs[0]), 32'd0);

        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        step(1'b1, 16'h01FF, 1'b1, 1'b0);
        chk("sim_full_fill0", 32'(fill[0]), 32'd7);
        chk("sim_full_fill1", 32'(fill[1]), 32'd7);
        chk("sim_full_ovs",   32'(ovs[0]),  32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h02AA, 1'b1, 1'b0);
        chk("sim_mid_fill0", 32'(fill[0]), 32'd4);
        chk("sim_mid_fill1", 32'(fill[1]), 32'd4);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1);

        step(1'b1, 16'hABCD, 1'b0, 1'b0);
        chk("lat_k", 32'(rvalid[1]), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("lat_k1_valid", 32'(rvalid[1]), 32'd1);
        chk("lat_k1_data",  32'(rdata[1]),  32'hABCD);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("lat_pop_valid", 32'(rvalid[1]), 32'd0);
        chk("lat_pop_fill",  32'(fill[1]),   32'd0);

        for (int b = 0; b < 20; b++) begin
            int nw = (b < 10) ? 3 : 2;
            for (int i = 0; i < nw; i++) step(1'b1, 16'($urandom), 1'($urandom), 1'b0);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) step(1'b0, '0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1);

        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0050 + i), 1'b0, 1'b0);
        chk("rst_mid_fill", 32'(fill[0]), 32'd5);
        do_reset();
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("rst_first1", 32'(rdata[1]), 32'h1234);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("rst_first0", 32'(rdata[0]), 32'h1234);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
